// File: rtl/mem_router_pkg.sv
// Shared types and register map for the memory-mapped request router.
package mem_router_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_PERIPH,
      ST_STOR,
      ST_RESP_ERR
   } state_e;

   typedef enum logic [2:0] {
      ERR_NONE,
      ERR_MISALIGNED,
      ERR_UNMAPPED,
      ERR_RO_WRITE,
      ERR_BAD_BE,
      ERR_RESERVED,
      ERR_EXT_WRITE,
      ERR_TIMEOUT
   } err_cause_e;

   localparam logic [7:0] OFF_GPIO_DIR   = 8'h00;
   localparam logic [7:0] OFF_GPIO_OUT   = 8'h04;
   localparam logic [7:0] OFF_GPIO_IN    = 8'h08;
   localparam logic [7:0] OFF_TIMER_STAT = 8'h0C;
   localparam logic [7:0] OFF_TIMER_SET  = 8'h10;

   localparam logic [31:0] WIN_BYTES = 32'd256;

   function automatic logic [31:0] apply_be(input logic [31:0] old_v,
                                            input logic [31:0] new_v,
                                            input logic [3:0]  be);
      logic [31:0] res;
      res = old_v;
      for (int b = 0; b < 4; b++) begin
         if (be[b]) res[8*b +: 8] = new_v[8*b +: 8];
      end
      return res;
   endfunction

endpackage

// File: rtl/mem_router_sync_2ff.sv
// Two-flop synchroniser for asynchronous pad inputs.
module sync_2ff #(
   parameter int unsigned WIDTH = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] d_i,
   output logic [WIDTH-1:0] q_o
);

   logic [WIDTH-1:0] meta_q;
   logic [WIDTH-1:0] sync_q;

   // NOTE: non-blocking assignments keep the two stages a true pipeline.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         meta_q <= '0;
         sync_q <= '0;
      end else begin
         meta_q <= d_i;
         sync_q <= meta_q;
      end
   end

   assign q_o = sync_q;

endmodule

// File: rtl/mem_router.sv
// Routes data-port requests to GPIO/timer registers, to storage (with timeout),
// or to an error response; exactly one response per accepted request.
module mem_router
   import mem_router_pkg::*;
#(
   parameter int unsigned MEM_W       = 32,
   parameter int unsigned GPIO_W      = 10,
   parameter int unsigned N_TIMERS    = 1,
   parameter logic [31:0] PERIPH_BASE = 32'h0000_0100,
   parameter logic [31:0] STOR_BASE   = 32'h0000_1000,
   parameter logic [31:0] EXT_BASE    = 32'h0000_2000,
   parameter int unsigned TIMEOUT     = 1024
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   vproc_mem_req_o,
   input  logic [31:0]            vproc_mem_addr_o,
   input  logic                   vproc_mem_we_o,
   input  logic [MEM_W/8-1:0]     vproc_mem_be_o,
   input  logic [MEM_W-1:0]       vproc_mem_wdata_o,
   output logic                   vproc_mem_rvalid_i,
   output logic                   vproc_mem_err_i,
   output logic [MEM_W-1:0]       vproc_mem_rdata_i,
   output logic                   stor_req,
   output logic                   stor_we,
   output logic [31:0]            stor_addr,
   output logic [MEM_W/8-1:0]     stor_be,
   output logic [MEM_W-1:0]       stor_wdata,
   input  logic                   stor_valid,
   input  logic [MEM_W-1:0]       stor_rdata,
   input  logic [N_TIMERS-1:0]    timer_is_high,
   output logic [N_TIMERS*32-1:0] timer_set_val,
   output logic [N_TIMERS-1:0]    set_timer,
   input  logic [GPIO_W-1:0]      gpio_i,
   output logic [GPIO_W-1:0]      gpio_o,
   output logic [GPIO_W-1:0]      gpio_oe
);

   localparam int unsigned CNT_W = $clog2(TIMEOUT);

   state_e                     state_q;
   logic                       rvalid_q, err_q;
   logic [MEM_W-1:0]           rdata_q;
   logic                       stor_req_q, stor_we_q;
   logic [31:0]                stor_addr_q;
   logic [MEM_W/8-1:0]         stor_be_q;
   logic [MEM_W-1:0]           stor_wdata_q;
   logic [CNT_W-1:0]           tmo_q;
   logic [GPIO_W-1:0]          dir_q, out_q;
   logic [N_TIMERS-1:0]        set_timer_q;
   logic [N_TIMERS-1:0][31:0]  timer_val_q;

   logic [GPIO_W-1:0] gpio_sync;
   logic              in_win, tmr_hit, dec_reg, dec_stor;
   logic [7:0]        off;
   logic [2:0]        tmr_idx;
   logic [31:0]       reg_rdata;
   err_cause_e        dec_cause;

   sync_2ff #(.WIDTH(GPIO_W)) u_gpio_sync (
      .clk (clk),
      .rst (rst),
      .d_i (gpio_i),
      .q_o (gpio_sync)
   );

   assign in_win  = (vproc_mem_addr_o >= PERIPH_BASE) &&
                    (vproc_mem_addr_o <  PERIPH_BASE + WIN_BYTES);
   assign off     = vproc_mem_addr_o[7:0] - PERIPH_BASE[7:0];
   assign tmr_idx = off[4:2] - 3'd4;
   assign tmr_hit = (off >= OFF_TIMER_SET) && (off < OFF_TIMER_SET + 8'(4 * N_TIMERS));

   // NOTE: every output gets a default first so no path infers a latch.
   always_comb begin
      dec_cause = ERR_NONE;
      dec_stor  = 1'b0;
      reg_rdata = '0;
      if (in_win) begin
         if (vproc_mem_addr_o[1:0] != 2'b00) begin
            dec_cause = ERR_MISALIGNED;
         end else begin
            case (off)
               OFF_GPIO_DIR:   reg_rdata = 32'(dir_q);
               OFF_GPIO_OUT:   reg_rdata = 32'(out_q);
               OFF_GPIO_IN: begin
                  if (vproc_mem_we_o) dec_cause = ERR_RO_WRITE;
                  else                reg_rdata = 32'(gpio_sync);
               end
               OFF_TIMER_STAT: begin
                  if (vproc_mem_we_o) dec_cause = ERR_RO_WRITE;
                  else                reg_rdata = 32'(timer_is_high);
               end
               default: begin
                  if (!tmr_hit)                                   dec_cause = ERR_UNMAPPED;
                  else if (vproc_mem_we_o && vproc_mem_be_o != '1) dec_cause = ERR_BAD_BE;
               end
            endcase
         end
      end else if (vproc_mem_addr_o >= STOR_BASE) begin
         if (vproc_mem_we_o && vproc_mem_addr_o >= EXT_BASE) dec_cause = ERR_EXT_WRITE;
         else                                                dec_stor  = 1'b1;
      end else begin
         dec_cause = ERR_RESERVED;
      end
   end

   assign dec_reg = in_win && (dec_cause == ERR_NONE);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= ST_IDLE;
         rvalid_q     <= 1'b0;
         err_q        <= 1'b0;
         rdata_q      <= '0;
         stor_req_q   <= 1'b0;
         stor_we_q    <= 1'b0;
         stor_addr_q  <= '0;
         stor_be_q    <= '0;
         stor_wdata_q <= '0;
         tmo_q        <= '0;
         dir_q        <= '1;
         out_q        <= '0;
         set_timer_q  <= '0;
         timer_val_q  <= '0;
      end else begin
         rvalid_q    <= 1'b0;
         err_q       <= 1'b0;
         rdata_q     <= '0;
         set_timer_q <= '0;
         case (state_q)
            ST_IDLE: begin
               if (vproc_mem_req_o) begin
                  if (dec_reg) begin
                     state_q  <= ST_PERIPH;
                     rvalid_q <= 1'b1;
                     if (vproc_mem_we_o) begin
                        if (off == OFF_GPIO_DIR)
                           dir_q <= GPIO_W'(apply_be(32'(dir_q), vproc_mem_wdata_o[31:0],
                                                     vproc_mem_be_o[3:0]));
                        if (off == OFF_GPIO_OUT)
                           out_q <= GPIO_W'(apply_be(32'(out_q), vproc_mem_wdata_o[31:0],
                                                     vproc_mem_be_o[3:0]));
                        for (int i = 0; i < N_TIMERS; i++) begin
                           if (tmr_hit && tmr_idx == 3'(i)) begin
                              set_timer_q[i] <= 1'b1;
                              timer_val_q[i] <= vproc_mem_wdata_o[31:0];
                           end
                        end
                     end else begin
                        rdata_q <= MEM_W'(reg_rdata);
                     end
                  end else if (dec_stor) begin
                     state_q      <= ST_STOR;
                     stor_req_q   <= 1'b1;
                     stor_we_q    <= vproc_mem_we_o;
                     stor_addr_q  <= vproc_mem_addr_o;
                     stor_be_q    <= vproc_mem_be_o;
                     stor_wdata_q <= vproc_mem_wdata_o;
                     tmo_q        <= '0;
                  end else begin
                     state_q <= ST_RESP_ERR;
                     err_q   <= 1'b1;
                  end
               end
            end
            ST_PERIPH, ST_RESP_ERR: state_q <= ST_IDLE;
            ST_STOR: begin
               // A completion in the final timeout cycle still counts as success.
               if (stor_valid) begin
                  state_q    <= ST_IDLE;
                  stor_req_q <= 1'b0;
                  rvalid_q   <= 1'b1;
                  rdata_q    <= stor_rdata;
                  tmo_q      <= '0;
               end else if (tmo_q == CNT_W'(TIMEOUT - 1)) begin
                  state_q    <= ST_IDLE;
                  stor_req_q <= 1'b0;
                  err_q      <= 1'b1;
                  tmo_q      <= '0;
               end else begin
                  tmo_q <= tmo_q + CNT_W'(1);
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign vproc_mem_rvalid_i = rvalid_q;
   assign vproc_mem_err_i    = err_q;
   assign vproc_mem_rdata_i  = rdata_q;
   assign stor_req           = stor_req_q;
   assign stor_we            = stor_we_q;
   assign stor_addr          = stor_addr_q;
   assign stor_be            = stor_be_q;
   assign stor_wdata         = stor_wdata_q;
   assign set_timer          = set_timer_q;
   assign timer_set_val      = timer_val_q;
   assign gpio_o             = out_q;
   assign gpio_oe            = ~dir_q;

endmodule

// File: tb/tb_mem_router.sv
// Directed plus randomized bench for mem_router against a rule-level reference model.
module tb_mem_router;

   localparam int          MEM_W    = 32;
   localparam int          GPIO_W   = 10;
   localparam int          N_TIMERS = 2;
   localparam int          TIMEOUT  = 16;
   localparam logic [31:0] PB       = 32'h0000_0100;
   localparam logic [31:0] SB       = 32'h0000_1000;
   localparam logic [31:0] EB       = 32'h0000_2000;
   localparam logic [31:0] GMASK    = 32'h0000_03FF;

   logic                   clk = 1'b0;
   logic                   rst = 1'b1;
   logic                   req = 1'b0;
   logic [31:0]            addr = '0;
   logic                   we = 1'b0;
   logic [3:0]             be = '0;
   logic [31:0]            wdata = '0;
   logic                   rvalid, err;
   logic [31:0]            rdata;
   logic                   stor_req, stor_we;
   logic [31:0]            stor_addr;
   logic [3:0]             stor_be;
   logic [31:0]            stor_wdata;
   logic                   stor_valid = 1'b0;
   logic [31:0]            stor_rdata = '0;
   logic [N_TIMERS-1:0]    timer_is_high = '0;
   logic [N_TIMERS*32-1:0] timer_set_val;
   logic [N_TIMERS-1:0]    set_timer;
   logic [GPIO_W-1:0]      gpio_i = '0;
   logic [GPIO_W-1:0]      gpio_o, gpio_oe;

   mem_router #(
      .MEM_W(MEM_W), .GPIO_W(GPIO_W), .N_TIMERS(N_TIMERS),
      .PERIPH_BASE(PB), .STOR_BASE(SB), .EXT_BASE(EB), .TIMEOUT(TIMEOUT)
   ) dut (
      .clk(clk), .rst(rst),
      .vproc_mem_req_o(req), .vproc_mem_addr_o(addr), .vproc_mem_we_o(we),
      .vproc_mem_be_o(be), .vproc_mem_wdata_o(wdata),
      .vproc_mem_rvalid_i(rvalid), .vproc_mem_err_i(err), .vproc_mem_rdata_i(rdata),
      .stor_req(stor_req), .stor_we(stor_we), .stor_addr(stor_addr), .stor_be(stor_be),
      .stor_wdata(stor_wdata), .stor_valid(stor_valid), .stor_rdata(stor_rdata),
      .timer_is_high(timer_is_high), .timer_set_val(timer_set_val), .set_timer(set_timer),
      .gpio_i(gpio_i), .gpio_o(gpio_o), .gpio_oe(gpio_oe)
   );

   always #5 clk = ~clk;

   int          n_checks = 0;
   int          n_errors = 0;
   logic [31:0] m_dir = GMASK;
   logic [31:0] m_out = '0;
   logic [31:0] m_tval [N_TIMERS];

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] merge(input logic [31:0] old_v, input logic [31:0] new_v,
                                         input logic [3:0] bmask);
      logic [31:0] m;
      m = {{8{bmask[3]}}, {8{bmask[2]}}, {8{bmask[1]}}, {8{bmask[0]}}};
      return (old_v & ~m) | (new_v & m);
   endfunction

   // Reference model: kind 1 = success, 2 = error. Applies register side effects.
   task automatic model(input logic [31:0] a, input logic w, input logic [3:0] bm,
                        input logic [31:0] wd, output int kind, output logic [31:0] rd,
                        output logic [N_TIMERS-1:0] strobe, output bit to_stor);
      logic [31:0] o;
      int          ti;
      kind = 2; rd = '0; strobe = '0; to_stor = 1'b0;
      if (a >= PB && a < PB + 32'd256) begin
         o = a - PB;
         if (a % 4 != 0) return;
         if (o == 0) begin
            kind = 1;
            if (w) m_dir = merge(m_dir, wd, bm) & GMASK; else rd = m_dir;
         end else if (o == 4) begin
            kind = 1;
            if (w) m_out = merge(m_out, wd, bm) & GMASK; else rd = m_out;
         end else if (o == 8) begin
            if (!w) begin kind = 1; rd = 32'(gpio_i); end
         end else if (o == 12) begin
            if (!w) begin kind = 1; rd = 32'(timer_is_high); end
         end else if (o >= 16 && o < 16 + 4 * N_TIMERS) begin
            ti = int'(o - 32'd16) / 4;
            if (!w) kind = 1;
            else if (bm == 4'hF) begin kind = 1; m_tval[ti] = wd; strobe[ti] = 1'b1; end
         end
      end else if (a >= SB) begin
         if (!(w && a >= EB)) begin kind = 1; to_stor = 1'b1; end
      end
   endtask

   // Issues one request and answers storage after lat stor_req cycles (0 = never).
   task automatic xact(input logic [31:0] a, input logic w, input logic [3:0] bm,
                       input logic [31:0] wd, input int lat, input logic [31:0] sdata,
                       output int kind, output logic [31:0] rd, output int sreq_n,
                       output int resp_c);
      kind = 0; rd = '0; sreq_n = 0; resp_c = 0;
      req = 1'b1; addr = a; we = w; be = bm; wdata = wd;
      for (int c = 1; c <= 40; c++) begin
         @(posedge clk); #1;
         req = 1'b0; stor_valid = 1'b0;
         if (rvalid || err) begin
            kind = rvalid ? (err ? 3 : 1) : 2;
            rd = rdata; resp_c = c;
            break;
         end
         if (stor_req) begin
            sreq_n++;
            if (sreq_n == 1) begin
               check("stor_fields", {stor_we, stor_be, stor_addr}, {w, bm, a});
               check("stor_wdata", stor_wdata, wd);
            end
            if (sreq_n == lat) begin stor_valid = 1'b1; stor_rdata = sdata; end
         end
      end
   endtask

   task automatic run(input string tag, input logic [31:0] a, input logic w,
                      input logic [3:0] bm, input logic [31:0] wd, input int lat,
                      input logic [31:0] sdata);
      int                  ek, k, sn, rc, exp_rc, exp_sn;
      logic [31:0]         erd, rd;
      logic [N_TIMERS-1:0] est;
      bit                  ts;
      model(a, w, bm, wd, ek, erd, est, ts);
      if (ts && (lat == 0 || lat > TIMEOUT)) begin
         ek = 2; exp_rc = TIMEOUT + 1; exp_sn = TIMEOUT;
      end else if (ts) begin
         exp_rc = lat + 1; exp_sn = lat;
      end else begin
         exp_rc = 1; exp_sn = 0;
      end
      xact(a, w, bm, wd, lat, sdata, k, rd, sn, rc);
      check({tag, "/kind"}, k, ek);
      check({tag, "/resp_cycle"}, rc, exp_rc);
      check({tag, "/stor_req_cycles"}, sn, exp_sn);
      if (!(ts && w)) check({tag, "/rdata"}, rd, (ek == 1 && !w) ? (ts ? sdata : erd) : 32'h0);
      check({tag, "/set_timer"}, set_timer, est);
      check({tag, "/timer_val"}, timer_set_val, {m_tval[1], m_tval[0]});
      check({tag, "/gpio"}, {gpio_oe, gpio_o}, {GPIO_W'(~m_dir), GPIO_W'(m_out)});
      @(posedge clk); #1;
      stor_valid = 1'b0;
      check({tag, "/after"}, {rvalid, err, stor_req, set_timer, rdata}, '0);
   endtask

   initial begin
      logic [31:0] a, wd;
      logic        w;
      logic [3:0]  bm;
      int          lat, sel, stray;

      m_tval = '{default: 32'h0};
      gpio_i = 10'h2A5;
      timer_is_high = 2'b01;
      #2 rst = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_resp", {rvalid, err}, 2'b00);
      check("rst_rdata", rdata, 0);
      check("rst_stor_req", stor_req, 0);
      check("rst_stor_fields", {stor_we, stor_be, stor_addr}, 0);
      check("rst_stor_wdata", stor_wdata, 0);
      check("rst_set_timer", set_timer, 0);
      check("rst_timer_val", timer_set_val, 0);
      check("rst_gpio_o", gpio_o, 0);
      check("rst_gpio_oe", gpio_oe, 0);
      rst = 1'b1;
      @(posedge clk); #1;

      run("dir_wr",      PB + 32'h00, 1'b1, 4'hF, 32'h0000_0000, 0, 0);
      run("out_wr",      PB + 32'h04, 1'b1, 4'hF, 32'h0000_0155, 0, 0);
      run("dir_rd",      PB + 32'h00, 1'b0, 4'hF, 0, 0, 0);
      run("out_rd",      PB + 32'h04, 1'b0, 4'hF, 0, 0, 0);
      run("dir_be",      PB + 32'h00, 1'b1, 4'h2, 32'hFFFF_FF00, 0, 0);
      run("out_input",   PB + 32'h04, 1'b1, 4'hF, 32'h0000_03FF, 0, 0);
      run("in_rd",       PB + 32'h08, 1'b0, 4'hF, 0, 0, 0);
      run("stat_rd",     PB + 32'h0C, 1'b0, 4'hF, 0, 0, 0);
      run("tset1",       PB + 32'h14, 1'b1, 4'hF, 32'd500, 0, 0);
      run("tset1_be3",   PB + 32'h14, 1'b1, 4'h3, 32'd77, 0, 0);
      run("tset0",       PB + 32'h10, 1'b1, 4'hF, 32'h1234_5678, 0, 0);
      run("tset_rd",     PB + 32'h10, 1'b0, 4'hF, 0, 0, 0);
      run("in_wr",       PB + 32'h08, 1'b1, 4'hF, 32'h1, 0, 0);
      run("stat_wr",     PB + 32'h0C, 1'b1, 4'hF, 32'h1, 0, 0);
      run("tset2_none",  PB + 32'h18, 1'b1, 4'hF, 32'h9, 0, 0);
      run("unmapped",    PB + 32'h30, 1'b0, 4'hF, 0, 0, 0);
      run("stor_rd",     SB + 32'h40, 1'b0, 4'hF, 0, 5, 32'hDEAD_BEEF);
      run("stor_wr",     SB + 32'h80, 1'b1, 4'h5, 32'h0000_1234, 2, 0);
      run("stor_tmo",    SB + 32'h04, 1'b0, 4'hF, 0, 0, 0);
      run("stor_edge",   SB + 32'h08, 1'b0, 4'hF, 0, TIMEOUT, 32'hCAFE_F00D);
      run("ext_wr",      EB,          1'b1, 4'hF, 32'h1, 1, 0);
      run("ext_rd",      EB + 32'h10, 1'b0, 4'hF, 0, 3, 32'h0BAD_F00D);
      run("reserved",    32'h0000_0FF0, 1'b0, 4'hF, 0, 0, 0);
      run("misaligned",  PB + 32'h02, 1'b0, 4'hF, 0, 0, 0);

      gpio_i = 10'($urandom);
      timer_is_high = 2'($urandom);
      repeat (3) @(posedge clk);
      #1;
      for (int i = 0; i < 60; i++) begin
         sel = $urandom_range(0, 7);
         case (sel)
            0, 1, 2: a = PB + 32'($urandom_range(0, 13) * 4);
            3:       a = PB + 32'($urandom_range(0, 15) * 4 + $urandom_range(1, 3));
            4:       a = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 32'hFF))
                                                     : 32'($urandom_range(32'h200, 32'hFFF));
            5, 6:    a = SB + ($urandom & 32'h0000_1FFC);
            default: a = EB + ($urandom & 32'h0000_0FFC);
         endcase
         w   = 1'($urandom_range(0, 1));
         bm  = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
         wd  = $urandom;
         lat = $urandom_range(1, 6);
         run("rand", a, w, bm, wd, lat, $urandom);
      end

      req = 1'b1; addr = SB + 32'h20; we = 1'b0; be = 4'hF;
      @(posedge clk); #1;
      req = 1'b0;
      check("midrst_pre", stor_req, 1);
      @(posedge clk); #1;
      rst = 1'b0;
      #1;
      check("midrst_async", {stor_req, rvalid, err}, 3'b000);
      @(posedge clk); #1;
      rst = 1'b1;
      m_dir = GMASK; m_out = '0; m_tval = '{default: 32'h0};
      stray = 0;
      stor_valid = 1'b1; stor_rdata = 32'h5555_AAAA;
      for (int c = 0; c < 5; c++) begin
         @(posedge clk); #1;
         stor_valid = 1'b0;
         if (rvalid || err || stor_req) stray++;
      end
      check("midrst_no_resp", stray, 0);
      run("post_rst_dir", PB, 1'b0, 4'hF, 0, 0, 0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/mem_router.md
# mem_router

Parametrised memory-mapped request router between the Vicuna/Ibex data port and the chip's peripherals and storage. Decodes each request into a peripheral register window (GPIO_W-pin GPIO, N_TIMERS digital timers), the SRAM/external storage window (storage controller handshake with timeout), or reserved space. Returns exactly one response (rvalid or err) per accepted request. It supersedes the single-pin, single-timer decoder used so far.

## Interface
- MEM_W, 32: data bus width in bits (32 only for peripheral registers; wider buses zero-extend reads).
- GPIO_W, 10: number of GPIO pins, 1..32.
- N_TIMERS, 1: number of digital timers, 1..8.
- PERIPH_BASE, 32'h0000_0100: base of the peripheral register window (256 B).
- STOR_BASE, 32'h0000_1000: first storage address; everything ≥ STOR_BASE goes to storage.
- EXT_BASE, 32'h0000_2000: first read-only external storage address.
- TIMEOUT, 1024: max cycles waiting for stor_valid; ≥ 2.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  reset, asynchronous, active-low.
- vproc_mem_req_o  in  1  request strobe, sampled only in IDLE.
- vproc_mem_addr_o  in  32  byte address.
- vproc_mem_we_o  in  1  1 = write.
- vproc_mem_be_o  in  MEM_W/8  byte enables.
- vproc_mem_wdata_o  in  MEM_W  write data.
- vproc_mem_rvalid_i  out  1  one-cycle success response (reads and writes).
- vproc_mem_err_i  out  1  one-cycle error response.
- vproc_mem_rdata_i  out  MEM_W  read data, valid with rvalid, else 0.
- stor_req  out  1  held high while a storage access is outstanding.
- stor_we, stor_addr[32], stor_be[MEM_W/8], stor_wdata[MEM_W]  out  latched request fields.
- stor_valid  in  1  storage done; stor_rdata[MEM_W] in valid with it.
- timer_is_high  in  N_TIMERS  timer status.
- timer_set_val  out  N_TIMERS×32  load value per timer.
- set_timer  out  N_TIMERS  one-cycle load strobe per timer.
- gpio_i  in  GPIO_W  pad inputs (asynchronous).
- gpio_o  out  GPIO_W  pad output values.
- gpio_oe  out  GPIO_W  pad output enables (= ~dir).

## Operation
- Register window (word offsets from PERIPH_BASE): 0x00 GPIO_DIR (RW, 1 = input, reset all-ones); 0x04 GPIO_OUT (RW, reset 0); 0x08 GPIO_IN (RO, synchronised pins); 0x0C TIMER_STAT (RO, bit i = timer_is_high[i]); 0x10+4i TIMER_SET[i] (WO, reads return 0). Bits ≥ GPIO_W / ≥ N_TIMERS read 0, writes ignored.
- GPIO_DIR/GPIO_OUT writes honour byte enables; TIMER_SET requires be all-ones, else err.
- Errors (no side effects): addr[1:0]≠0 in register window; unmapped offset; write to RO register; address < STOR_BASE outside register window (reserved); write at ≥ EXT_BASE; storage timeout.
- Write to GPIO_OUT bit whose pin is input: value stored, pin stays tri-stated (not an error).
- States: IDLE → PERIPH (register hit) | STOR (storage hit) | RESP_ERR (decode error). PERIPH → IDLE after one cycle. STOR → IDLE on stor_valid or timeout. RESP_ERR → IDLE.
- Requests arriving outside IDLE are ignored; requester waits for the response.

## Timing
- Reset: all outputs 0 except gpio_oe = 0 (all inputs); state IDLE; timeout counter 0.
- Register access: req at cycle t → rvalid/err registered at t+1; GPIO_OUT/DIR update visible on pins at t+1; set_timer pulses at t+1.
- GPIO_IN: 2-flop synchroniser, pin change visible in reads 2 cycles later.
- Storage: stor_req high from t+1 until the cycle stor_valid is seen (cycle s); response and stor_req low at s+1; stor_rdata captured at s.
- Timeout: counter increments each STOR cycle; reaching TIMEOUT drops stor_req and pulses err next cycle; a stor_valid in that same cycle wins (success).
- rvalid and err are never high together; next request accepted at the response cycle's IDLE (back-to-back period 2 cycles for registers).
- Asynchronous reset mid-access: stor_req drops immediately, no response issued.

## Structure
- mem_router_pkg: state enum, register offset localparams, error-cause enum.
- Sub-module sync_2ff (parametrised width) for gpio_i.

## Test plan
- Write 0x0000_0000 to GPIO_DIR then 0x155 to GPIO_OUT (GPIO_W=10) → gpio_oe=0x3FF, gpio_o=0x155, two rvalid pulses at t+1.
- Write 32'd500 to TIMER_SET[1] with be=4'hF (N_TIMERS=2) → set_timer=2'b10 one cycle, timer_set_val[1]=500; with be=4'h3 → err, no strobe.
- Read STOR_BASE+0x40, stor_valid after 5 cycles with rdata 0xDEAD_BEEF → rvalid with that data one cycle after stor_valid.
- Storage never answers (TIMEOUT=16) → stor_req high 16 cycles, then err pulse, state IDLE.
- Write to EXT_BASE, read 0x0000_0FF0, misaligned PERIPH_BASE+0x02 → three err pulses, no stor_req.
- Reset asserted while stor_req high → stor_req low asynchronously, no rvalid/err after release.
